hazard_ctrl: RTL

//  Pipeline sequencer for the 16-bit 5-stage core. Drives hold/flush for PC, IF/ID, ID/EX and the back end.

---
 rtl/hazard_ctrl_pkg.sv | 59 +++++
 rtl/hazard_ctrl_detect.sv | 27 ++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: sequencer state codes,
// the bundle of pipeline control lines, and the canned control patterns
// for each kind of cycle.
package hazard_ctrl_pkg;

    // Sequencer state codes (one bit, kept compatible with the legacy encoding)
    localparam logic HZ_RUN  = 1'b0;
    localparam logic HZ_MEMW = 1'b1;

    // All pipeline control lines driven by the sequencer
    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_rst;
        logic idex_rst;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Whole pipe frozen while the MEM stage owns the instruction RAM port
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c           = CTRL_IDLE;
        c.pc_hold   = 1'b1;
        c.ifid_hold = 1'b1;
        c.pipe_hold = 1'b1;
        return c;
    endfunction

    // Redirect: squash the two younger instructions, let PC take the target
    function automatic ctrl_t ctrl_branch();
        ctrl_t c;
        c          = CTRL_IDLE;
        c.ifid_rst = 1'b1;
        c.idex_rst = 1'b1;
        return c;
    endfunction

    // Load-use: keep fetch and decode, insert one bubble into EX
    function automatic ctrl_t ctrl_load_use();
        ctrl_t c;
        c           = CTRL_IDLE;
        c.pc_hold   = 1'b1;
        c.ifid_hold = 1'b1;
        c.idex_rst  = 1'b1;
        return c;
    endfunction

    // Fetch slot stolen: PC waits, decode receives a NOP
    function automatic ctrl_t ctrl_steal();
        ctrl_t c;
        c          = CTRL_IDLE;
        c.pc_hold  = 1'b1;
        c.ifid_rst = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use detector: flags an EX-stage load whose destination is read by
// the instruction currently in decode. Purely combinational.
module hazard_ctrl_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic             mem_read,
    input  logic [REG_W-1:0] dst,
    input  logic [REG_W-1:0] src_a,
    input  logic             src_a_vld,
    input  logic [REG_W-1:0] src_b,
    input  logic             src_b_vld,
    output logic             load_use
);

    logic hit_a;
    logic hit_b;

    // Compare each used decode source against the load destination
    always_comb begin
        hit_a    = src_a_vld && (src_a == dst);
        hit_b    = src_b_vld && (src_b == dst);
        load_use = mem_read && (hit_a || hit_b);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 16-bit 5-stage core. Resolves branch redirect,
// load-use and the structural conflict on the shared instruction RAM port,
// and keeps a saturating count of cycles in which the PC was held.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int REG_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             BranchTaken,
    input  logic             ExMemRead,
    input  logic [REG_W-1:0] ExDst,
    input  logic [REG_W-1:0] IdSrcA,
    input  logic             IdSrcAVld,
    input  logic [REG_W-1:0] IdSrcB,
    input  logic             IdSrcBVld,
    input  logic             MemInsReq,
    input  logic             ClrStat,
    output logic             PcHold,
    output logic             IfIdHold,
    output logic             IfIdRst,
    output logic             IdExRst,
    output logic             PipeHold,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int             CW        = $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_START = CW'(MEM_WAIT - 1);
    localparam bit             MULTI     = (MEM_WAIT > 1);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

    logic             st;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] stall;
    logic             load_use;
    logic             freeze;
    logic             steal;
    logic             enter_memw;
    ctrl_t            ctrl;

    hazard_ctrl_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .mem_read  (ExMemRead),
        .dst       (ExDst),
        .src_a     (IdSrcA),
        .src_a_vld (IdSrcAVld),
        .src_b     (IdSrcB),
        .src_b_vld (IdSrcBVld),
        .load_use  (load_use)
    );

    // Classify the structural part of this cycle: freeze, slot steal or neither
    always_comb begin
        freeze     = 1'b0;
        steal      = 1'b0;
        enter_memw = 1'b0;
        if (st == HZ_RUN) begin
            if (MemInsReq) begin
                if (MULTI) begin
                    freeze     = 1'b1;
                    enter_memw = 1'b1;
                end else begin
                    steal = 1'b1;
                end
            end
        end else begin
            if (cnt > CNT_ONE) begin
                freeze = 1'b1;
            end else if (cnt == CNT_ONE) begin
                steal = 1'b1;
            end
        end
    end

    // Pick the control pattern; a freeze masks branch and load-use entirely
    always_comb begin
        ctrl = CTRL_IDLE;
        if (!Rst) begin
            ctrl = CTRL_IDLE;
        end else if (freeze) begin
            ctrl = ctrl_freeze();
        end else if (BranchTaken) begin
            ctrl = ctrl_branch();
        end else if (load_use) begin
            ctrl = ctrl_load_use();
        end else if (steal) begin
            ctrl = ctrl_steal();
        end
    end

    assign PcHold      = ctrl.pc_hold;
    assign IfIdHold    = ctrl.ifid_hold;
    assign IfIdRst     = ctrl.ifid_rst;
    assign IdExRst     = ctrl.idex_rst;
    assign PipeHold    = ctrl.pipe_hold;
    assign StallCycles = stall;

    // Structural-wait sequencer: count down the port occupancy, then return to RUN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            st  <= HZ_RUN;
            cnt <= '0;
        end else if (st == HZ_RUN) begin
            if (enter_memw) begin
                st  <= HZ_MEMW;
                cnt <= CNT_START;
            end
        end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                st <= HZ_RUN;
            end
        end
    end

    // Saturating count of PC-hold cycles; a clear request beats the increment
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall <= '0;
        end else if (ClrStat) begin
            stall <= '0;
        end else if (ctrl.pc_hold && (stall != STALL_MAX)) begin
            stall <= stall + STALL_ONE;
        end
    end

endmodule
